// File: rtl/rv32i_types_pkg.sv
// Shared rv32i front-end types: fetch FSM state and queue entry layout.
package rv32i_types;

  localparam int unsigned XLEN_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] inst;
  } fetch_entry_t;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_unit_fifo.sv
// DEPTH-entry circular buffer of fetch entries with push, pop, flush and count.
module fetch_fifo
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_flush,
  input  logic                        i_push,
  input  entry_t                      i_push_data,
  input  logic                        i_pop,
  output entry_t                      o_head,
  output logic [cnt_width(DEPTH)-1:0] o_count,
  output logic                        o_empty,
  output logic                        o_full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Decoupled fetch front end: PC generator, one-outstanding I-cache FSM, instruction queue.
// Optional zero-latency bypass when the queue is empty: define FETCH_BYPASS_EN.
module fetch_queue_unit
  import rv32i_types::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0060
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   inst_read,
  output logic [XLEN-1:0]        inst_addr,
  input  logic                   inst_resp,
  input  logic [XLEN-1:0]        inst_rdata,
  output logic                   deq_valid,
  input  logic                   deq_ready,
  output logic [XLEN-1:0]        deq_inst,
  output logic [XLEN-1:0]        deq_pc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned CW = cnt_width(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_inst_addr;
  logic            r_inst_read;

  entry_t          w_head;
  entry_t          w_push_data;
  logic [CW-1:0]   w_count;
  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_resp_live;

  // A response is only useful if it answers the live path and no redirect kills it now.
  assign w_resp_live = (r_state == REQ) && inst_resp && !redirect;
  assign w_push_data = {r_fetch_pc, inst_rdata};
  assign w_pop       = deq_ready && !w_empty && !redirect;

`ifdef FETCH_BYPASS_EN
  logic w_bypass;
  assign w_bypass = w_resp_live && w_empty;
  assign w_push   = w_resp_live && !(w_bypass && deq_ready);

  always_comb begin
    deq_valid = !w_empty;
    deq_inst  = w_head.inst;
    deq_pc    = w_head.pc;
    if (w_bypass) begin
      deq_valid = 1'b1;
      deq_inst  = inst_rdata;
      deq_pc    = r_fetch_pc;
    end
  end
`else
  assign w_push    = w_resp_live;
  assign deq_valid = !w_empty;
  assign deq_inst  = w_head.inst;
  assign deq_pc    = w_head.pc;
`endif

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .i_flush     (redirect),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_empty     (w_empty),
    .o_full      (w_full)
  );

  // Request address is latched at issue so a redirect in flight cannot disturb it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_fetch_pc  <= RESET_PC;
      r_inst_addr <= RESET_PC;
      r_inst_read <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (redirect) begin
            r_fetch_pc <= redirect_pc;
          end else if (!w_full) begin
            r_state     <= REQ;
            r_inst_read <= 1'b1;
            r_inst_addr <= r_fetch_pc;
          end
        end
        REQ: begin
          if (redirect) begin
            r_fetch_pc <= redirect_pc;
            if (inst_resp) begin
              r_state     <= IDLE;
              r_inst_read <= 1'b0;
            end else begin
              r_state <= DROP;
            end
          end else if (inst_resp) begin
            r_fetch_pc  <= r_fetch_pc + XLEN'(4);
            r_state     <= IDLE;
            r_inst_read <= 1'b0;
          end
        end
        DROP: begin
          if (redirect) begin
            r_fetch_pc <= redirect_pc;
          end
          if (inst_resp) begin
            r_state     <= IDLE;
            r_inst_read <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_inst_read <= 1'b0;
        end
      endcase
    end
  end

  assign inst_read = r_inst_read;
  assign inst_addr = r_inst_addr;
  assign count     = w_count;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with a variable-latency I-cache model.
module tb_fetch_queue_unit;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_read;
  logic [31:0] inst_addr;
  logic        inst_resp;
  logic [31:0] inst_rdata;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_inst;
  logic [31:0] deq_pc;
  logic [2:0]  count;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          lat      = 1;
  int          lat_left = 0;
  bit          busy     = 0;
  logic [31:0] req_addr;
  logic [31:0] issued   [$];
  logic [31:0] pop_pc   [$];
  logic [31:0] pop_inst [$];

  fetch_queue_unit #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0000_0060)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_read   (inst_read),
    .inst_addr   (inst_addr),
    .inst_resp   (inst_resp),
    .inst_rdata  (inst_rdata),
    .deq_valid   (deq_valid),
    .deq_ready   (deq_ready),
    .deq_inst    (deq_inst),
    .deq_pc      (deq_pc),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache: request seen after an edge is answered `lat` cycles later with a one-cycle strobe.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      busy      = 1'b0;
      inst_resp = 1'b0;
    end else begin
      inst_resp = 1'b0;
      if (busy) begin
        if (lat_left <= 1) begin
          inst_resp  = 1'b1;
          inst_rdata = 32'hC0DE_0000 | req_addr;
          busy       = 1'b0;
        end else begin
          lat_left = lat_left - 1;
        end
      end else if (inst_read) begin
        busy     = 1'b1;
        req_addr = inst_addr;
        lat_left = lat;
        issued.push_back(inst_addr);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && deq_valid && deq_ready && !redirect) begin
      pop_pc.push_back(deq_pc);
      pop_inst.push_back(deq_inst);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset(input int new_lat);
    rst = 1'b0;
    tick(2);
    issued.delete();
    pop_pc.delete();
    pop_inst.delete();
    lat = new_lat;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int i;
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    deq_ready   = 1'b1;
    lat         = 1;
    tick(2);
    check("rst_inst_read", 32'(inst_read), 32'h0);
    check("rst_inst_addr", inst_addr, 32'h60);
    check("rst_deq_valid", 32'(deq_valid), 32'h0);
    check("rst_deq_inst", deq_inst, 32'h0);
    check("rst_deq_pc", deq_pc, 32'h0);
    check("rst_count", 32'(count), 32'h0);

    // Streaming, latency 1, consumer always ready
    rst = 1'b1;
    for (i = 0; i < 40 && pop_pc.size() < 3; i++) tick(1);
    check("t1_pops", 32'(pop_pc.size() >= 3), 32'h1);
    check("t1_addr0", q_at(issued, 0), 32'h60);
    check("t1_addr1", q_at(issued, 1), 32'h64);
    check("t1_addr2", q_at(issued, 2), 32'h68);
    check("t1_pc0", q_at(pop_pc, 0), 32'h60);
    check("t1_pc1", q_at(pop_pc, 1), 32'h64);
    check("t1_pc2", q_at(pop_pc, 2), 32'h68);
    check("t1_inst0", q_at(pop_inst, 0), 32'hC0DE_0060);
    check("t1_inst2", q_at(pop_inst, 2), 32'hC0DE_0068);

    // Fill with consumer stalled
    deq_ready = 1'b0;
    do_reset(1);
    tick(20);
    check("t2_nreq", 32'(issued.size()), 32'd4);
    check("t2_count", 32'(count), 32'd4);
    check("t2_read_full", 32'(inst_read), 32'h0);
    check("t2_head_pc", deq_pc, 32'h60);
    deq_ready = 1'b1;
    tick(1);
    deq_ready = 1'b0;
    tick(5);
    check("t2_nreq_after_pop", 32'(issued.size()), 32'd5);
    check("t2_addr4", q_at(issued, 4), 32'h70);
    check("t2_count_refill", 32'(count), 32'd4);

    // Push and pop on the same edge, pointers wrapping
    deq_ready = 1'b1;
    tick(1);
    deq_ready = 1'b0;
    check("t5_count_pop", 32'(count), 32'd3);
    for (i = 0; i < 10 && !inst_resp; i++) tick(1);
    check("t5_resp_seen", 32'(inst_resp), 32'h1);
    deq_ready = 1'b1;
    tick(1);
    deq_ready = 1'b0;
    check("t5_count_same", 32'(count), 32'd3);
    deq_ready = 1'b1;
    tick(30);
    check("t5_pc0", q_at(pop_pc, 0), 32'h60);
    check("t5_pc1", q_at(pop_pc, 1), 32'h64);
    check("t5_pc2", q_at(pop_pc, 2), 32'h68);
    check("t5_pc3", q_at(pop_pc, 3), 32'h6C);
    check("t5_pc4", q_at(pop_pc, 4), 32'h70);
    check("t5_pc5", q_at(pop_pc, 5), 32'h74);
    check("t5_pc6", q_at(pop_pc, 6), 32'h78);
    check("t5_inst5", q_at(pop_inst, 5), 32'hC0DE_0074);

    // Redirect while a request is in flight
    deq_ready = 1'b0;
    do_reset(3);
    for (i = 0; i < 40 && !(inst_read && inst_addr == 32'h68); i++) tick(1);
    check("t3_req68", inst_addr, 32'h68);
    check("t3_count_pre", 32'(count), 32'd2);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick(1);
    redirect = 1'b0;
    check("t3_count_flush", 32'(count), 32'd0);
    check("t3_deq_valid", 32'(deq_valid), 32'h0);
    check("t3_drop_read", 32'(inst_read), 32'h1);
    check("t3_drop_addr", inst_addr, 32'h68);
    tick(1);
    check("t3_drop_addr_hold", inst_addr, 32'h68);
    deq_ready = 1'b1;
    tick(12);
    check("t3_addr3", q_at(issued, 3), 32'h200);
    check("t3_first_pc", q_at(pop_pc, 0), 32'h200);
    check("t3_first_inst", q_at(pop_inst, 0), 32'hC0DE_0200);

    // Redirect coinciding with a response, then a second redirect while dropping
    do_reset(3);
    for (i = 0; i < 20 && !inst_resp; i++) tick(1);
    check("t4_resp_seen", 32'(inst_resp), 32'h1);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick(1);
    redirect = 1'b0;
    check("t4_idle_read", 32'(inst_read), 32'h0);
    for (i = 0; i < 10 && !(inst_read && inst_addr == 32'h100); i++) tick(1);
    check("t4_req100", inst_addr, 32'h100);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick(1);
    redirect_pc = 32'h300;
    tick(1);
    redirect = 1'b0;
    check("t4_drop_addr", inst_addr, 32'h100);
    tick(12);
    check("t4_nreq_addr1", q_at(issued, 1), 32'h100);
    check("t4_nreq_addr2", q_at(issued, 2), 32'h300);
    check("t4_first_pc", q_at(pop_pc, 0), 32'h300);
    check("t4_first_inst", q_at(pop_inst, 0), 32'hC0DE_0300);

    // Asynchronous reset in the middle of a request
    deq_ready = 1'b0;
    do_reset(3);
    for (i = 0; i < 30 && !(inst_read && count != 3'd0); i++) tick(1);
    check("t6_setup", 32'(inst_read && deq_valid), 32'h1);
    rst = 1'b0;
    #1;
    check("t6_read_async", 32'(inst_read), 32'h0);
    check("t6_valid_async", 32'(deq_valid), 32'h0);
    check("t6_count_async", 32'(count), 32'd0);
    tick(1);
    do_reset(1);
    tick(5);
    check("t6_first_addr", q_at(issued, 0), 32'h60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
